// File: rtl/text_console_ctrl_if.sv
// Character-stream, GPU-control and framebuffer-port signals of the text
// console controller, bundled so the controller and its environment share
// one connection point.
interface text_console_ctrl_if;
  // character stream
  logic        chValid;
  logic [7:0]  chData;
  logic        chReady;
  logic [2:0]  fgColor;
  logic [2:0]  bgColor;
  // status
  logic        busy;
  logic [5:0]  cursorCol;
  logic [4:0]  cursorRow;
  // GPU character renderer control
  logic [7:0]  gpuX;
  logic [8:0]  gpuY;
  logic [6:0]  gpuChar;
  logic [2:0]  gpuColor;
  logic        gpuDrawChar;
  logic        gpuDrawBox;
  logic [7:0]  gpuXMax;
  logic [8:0]  gpuYMax;
  logic        gpuDone;
  // GPU pixel write port (into the controller's mux)
  logic        gpuWriteMem;
  logic [2:0]  gpuWriteData;
  logic [16:0] gpuWriteAddress;
  // shared framebuffer write port
  logic        fbWrite;
  logic [2:0]  fbData;
  logic [16:0] fbAddress;

  // controller side
  modport slave (
    input  chValid, chData, fgColor, bgColor,
           gpuDone, gpuWriteMem, gpuWriteData, gpuWriteAddress,
    output chReady, busy, cursorCol, cursorRow,
           gpuX, gpuY, gpuChar, gpuColor, gpuDrawChar, gpuDrawBox, gpuXMax, gpuYMax,
           fbWrite, fbData, fbAddress
  );

  // environment side (character source, GPU, framebuffer)
  modport master (
    output chValid, chData, fgColor, bgColor,
           gpuDone, gpuWriteMem, gpuWriteData, gpuWriteAddress,
    input  chReady, busy, cursorCol, cursorRow,
           gpuX, gpuY, gpuChar, gpuColor, gpuDrawChar, gpuDrawBox, gpuXMax, gpuYMax,
           fbWrite, fbData, fbAddress
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Text console controller: buffers character codes in a small FIFO, tracks
// the text cursor, fills cell/row/screen backgrounds on the framebuffer port
// and hands printable glyphs to the GPU renderer. Its own fill writes and the
// GPU's pixel writes share one framebuffer write port.
module text_console_ctrl #(
  parameter int COLS       = 40,
  parameter int ROWS       = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk50,
  input  logic            reset,
  text_console_ctrl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // screen extents in pixels (6x10 cells) and last cursor positions
  localparam logic [7:0] SCR_X1   = 8'(COLS * 6 - 1);
  localparam logic [8:0] SCR_Y1   = 9'(ROWS * 10 - 1);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] ISSUE  = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] ADV    = 3'd5;

  // popped code together with the colours valid at pop time
  typedef struct packed {
    logic [7:0] code;
    logic [2:0] fg;
    logic [2:0] bg;
  } charLatch_t;

  logic [2:0]  state;
  charLatch_t  lat;

  // cursor in cells plus its pixel origin, kept in step without a multiplier
  logic [5:0]  col;
  logic [4:0]  row;
  logic [7:0]  cellX;
  logic [8:0]  cellY;

  // fill rectangle walker; fy0 is not needed after the start pixel is loaded
  logic [7:0]  fx, fx0, fx1;
  logic [8:0]  fy, fy1;
  logic        fillToIssue;

  // registered GPU draw parameters, stable from ISSUE through WAIT
  logic [7:0]  drawX;
  logic [8:0]  drawY;
  logic [6:0]  drawChar;
  logic [2:0]  drawColor;

  logic [7:0]  fifoMem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic        fifoEmpty, fifoFull, push, pop;

  logic        isPrint, rowWrap;
  logic [4:0]  nextRow;
  logic [8:0]  nextCellY;

  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign push      = bus.chValid && !fifoFull;
  assign pop       = (state == IDLE) && !fifoEmpty;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk50) begin
    if (push) fifoMem[wrPtr[AW-1:0]] <= bus.chData;
  end

  // FIFO pointers; a push into a full FIFO is dropped even if a pop happens
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // code class and the cursor position a row advance would land on
  always_comb begin
    isPrint   = (lat.code >= 8'h20) && (lat.code <= 8'h7E);
    rowWrap   = (row == ROW_LAST);
    nextRow   = rowWrap ? 5'd0 : row + 5'd1;
    nextCellY = rowWrap ? 9'd0 : cellY + 9'd10;
  end

  // control sequencer: pop, decode, fill, draw handshake, cursor advance
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat         <= '0;
      col         <= '0;
      row         <= '0;
      cellX       <= '0;
      cellY       <= '0;
      fx          <= '0;
      fx0         <= '0;
      fx1         <= '0;
      fy          <= '0;
      fy1         <= '0;
      fillToIssue <= 1'b0;
      drawX       <= '0;
      drawY       <= '0;
      drawChar    <= '0;
      drawColor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            lat   <= '{code: fifoMem[rdPtr[AW-1:0]], fg: bus.fgColor, bg: bus.bgColor};
            state <= DECODE;
          end
        end

        DECODE: begin
          if (isPrint) begin
            // clear the cell, then draw the glyph on top of it
            fx          <= cellX;
            fx0         <= cellX;
            fx1         <= cellX + 8'd5;
            fy          <= cellY;
            fy1         <= cellY + 9'd9;
            fillToIssue <= 1'b1;
            drawX       <= cellX;
            drawY       <= cellY;
            drawChar    <= lat.code[6:0];
            drawColor   <= lat.fg;
            state       <= FILL;
          end else begin
            case (lat.code)
              8'h0A: begin
                // line feed: column home, next row, clear that row
                col         <= '0;
                cellX       <= '0;
                row         <= nextRow;
                cellY       <= nextCellY;
                fx          <= '0;
                fx0         <= '0;
                fx1         <= SCR_X1;
                fy          <= nextCellY;
                fy1         <= nextCellY + 9'd9;
                fillToIssue <= 1'b0;
                state       <= FILL;
              end
              8'h0D: begin
                col   <= '0;
                cellX <= '0;
                state <= IDLE;
              end
              8'h08: begin
                // backspace erases the cell it steps back onto
                if (col != 6'd0) begin
                  col         <= col - 6'd1;
                  cellX       <= cellX - 8'd6;
                  fx          <= cellX - 8'd6;
                  fx0         <= cellX - 8'd6;
                  fx1         <= cellX - 8'd1;
                  fy          <= cellY;
                  fy1         <= cellY + 9'd9;
                  fillToIssue <= 1'b0;
                  state       <= FILL;
                end else begin
                  state <= IDLE;
                end
              end
              8'h0C: begin
                // form feed: clear everything and home the cursor
                col         <= '0;
                row         <= '0;
                cellX       <= '0;
                cellY       <= '0;
                fx          <= '0;
                fx0         <= '0;
                fx1         <= SCR_X1;
                fy          <= '0;
                fy1         <= SCR_Y1;
                fillToIssue <= 1'b0;
                state       <= FILL;
              end
              default: state <= IDLE;
            endcase
          end
        end

        FILL: begin
          // one pixel per cycle, row-major over the rectangle
          if (fx == fx1) begin
            fx <= fx0;
            if (fy == fy1) state <= fillToIssue ? ISSUE : IDLE;
            else           fy    <= fy + 9'd1;
          end else begin
            fx <= fx + 8'd1;
          end
        end

        ISSUE: state <= WAIT;

        WAIT: begin
          if (bus.gpuDone) state <= ADV;
        end

        ADV: begin
          if (col == COL_LAST) begin
            // wrap to the next row and clear it before accepting more input
            col         <= '0;
            cellX       <= '0;
            row         <= nextRow;
            cellY       <= nextCellY;
            fx          <= '0;
            fx0         <= '0;
            fx1         <= SCR_X1;
            fy          <= nextCellY;
            fy1         <= nextCellY + 9'd9;
            fillToIssue <= 1'b0;
            state       <= FILL;
          end else begin
            col   <= col + 6'd1;
            cellX <= cellX + 8'd6;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // status, GPU control and framebuffer port mux
  always_comb begin
    bus.chReady     = !fifoFull;
    bus.busy        = !fifoEmpty || (state != IDLE);
    bus.cursorCol   = col;
    bus.cursorRow   = row;
    bus.gpuX        = drawX;
    bus.gpuY        = drawY;
    bus.gpuChar     = drawChar;
    bus.gpuColor    = drawColor;
    bus.gpuDrawChar = (state == ISSUE);
    bus.gpuDrawBox  = 1'b0;
    bus.gpuXMax     = '0;
    bus.gpuYMax     = '0;
    // the GPU cannot be drawing during FILL, so the controller owns the port
    if (state == FILL) begin
      bus.fbWrite   = 1'b1;
      bus.fbData    = lat.bg;
      bus.fbAddress = {fy, fx};
    end else begin
      bus.fbWrite   = bus.gpuWriteMem;
      bus.fbData    = bus.gpuWriteData;
      bus.fbAddress = bus.gpuWriteAddress;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a full-size console with a behavioural GPU
// and a framebuffer image model, plus a narrow 4-column console used to
// reach the bottom-row wrap quickly.
module tb_text_console_ctrl;

  logic   clk50 = 1'b0;
  logic   reset = 1'b1;
  longint cyc   = 0;
  int     nCmp  = 0;
  int     nBad  = 0;

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  text_console_ctrl_if i0();
  text_console_ctrl_if i1();

  text_console_ctrl dut0 (.clk50(clk50), .reset(reset), .bus(i0));
  text_console_ctrl #(.COLS(4), .ROWS(24), .FIFO_DEPTH(8)) dut1 (.clk50(clk50), .reset(reset), .bus(i1));

  typedef struct packed {
    logic [7:0] x;
    logic [8:0] y;
    logic [6:0] ch;
    logic [2:0] c;
  } draw_t;

  localparam int C0 = 40;
  localparam int R0 = 24;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // glyph pattern the GPU model paints; pixel i of 48 lies at (i%6, i/6)
  function automatic bit glyphOn(input logic [6:0] ch, input int i);
    return ((int'(ch) + i) % 3) != 0;
  endfunction

  // ---------------- GPU model (48-cycle glyph draw) ----------------
  logic       g0Hold = 1'b0;
  int         g0Cnt;
  logic [7:0] g0X;
  logic [8:0] g0Y;
  logic [6:0] g0Ch;
  logic [2:0] g0Col;

  always @(posedge clk50 or posedge reset) begin
    if (reset) begin
      i0.gpuDone <= 1'b1;
      g0Cnt      <= 0;
      g0X <= '0; g0Y <= '0; g0Ch <= '0; g0Col <= '0;
    end else if (i0.gpuDrawChar) begin
      i0.gpuDone <= 1'b0;
      g0Cnt      <= 0;
      g0X <= i0.gpuX; g0Y <= i0.gpuY; g0Ch <= i0.gpuChar; g0Col <= i0.gpuColor;
    end else if (!i0.gpuDone && !g0Hold) begin
      g0Cnt <= g0Cnt + 1;
      if (g0Cnt == 47) i0.gpuDone <= 1'b1;
    end
  end

  always_comb begin
    i0.gpuWriteMem     = !i0.gpuDone && !g0Hold && glyphOn(g0Ch, g0Cnt);
    i0.gpuWriteData    = g0Col;
    i0.gpuWriteAddress = {g0Y + 9'(g0Cnt / 6), g0X + 8'(g0Cnt % 6)};
  end

  int g1Cnt;
  always @(posedge clk50 or posedge reset) begin
    if (reset) begin
      i1.gpuDone <= 1'b1;
      g1Cnt      <= 0;
    end else if (i1.gpuDrawChar) begin
      i1.gpuDone <= 1'b0;
      g1Cnt      <= 0;
    end else if (!i1.gpuDone) begin
      g1Cnt <= g1Cnt + 1;
      if (g1Cnt == 47) i1.gpuDone <= 1'b1;
    end
  end

  always_comb begin
    i1.gpuWriteMem     = 1'b0;
    i1.gpuWriteData    = '0;
    i1.gpuWriteAddress = '0;
  end

  // ---------------- framebuffer / draw monitors ----------------
  logic [2:0] obsFb [131072];
  logic [2:0] refFb [131072];
  draw_t      obsDraw[$];
  draw_t      expDraw[$];
  int         wr0, wr1, passErr;
  longint     firstWr0, drawCyc, pushCyc, idleCyc;
  int         last0, first1, last1;
  logic [7:0] lastX1;

  always @(negedge clk50) begin
    if (i0.fbWrite === 1'b1) obsFb[i0.fbAddress] = i0.fbData;
    if (i0.fbWrite === 1'b1 && i0.gpuWriteMem !== 1'b1) begin
      wr0++;
      last0 = int'(i0.fbAddress);
      if (firstWr0 < 0) firstWr0 = cyc;
    end
    if (i0.gpuWriteMem === 1'b1 &&
        (i0.fbWrite !== 1'b1 || i0.fbAddress !== i0.gpuWriteAddress || i0.fbData !== i0.gpuWriteData))
      passErr++;
    if (i0.gpuDrawChar === 1'b1) begin
      obsDraw.push_back('{x: i0.gpuX, y: i0.gpuY, ch: i0.gpuChar, c: i0.gpuColor});
      drawCyc = cyc;
    end
    if (i1.fbWrite === 1'b1) begin
      wr1++;
      if (first1 < 0) first1 = int'(i1.fbAddress);
      last1 = int'(i1.fbAddress);
    end
    if (i1.gpuDrawChar === 1'b1) lastX1 = i1.gpuX;
  end

  // ---------------- reference console model ----------------
  int refCol, refRow, expWr;

  task automatic refFill(input int x0, input int y0, input int w, input int h, input logic [2:0] c);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        refFb[(y0 + y) * 256 + x0 + x] = c;
    expWr += w * h;
  endtask

  task automatic refNewRow(input logic [2:0] bg);
    refRow = (refRow + 1) % R0;
    refFill(0, refRow * 10, C0 * 6, 10, bg);
  endtask

  task automatic refApply(input logic [7:0] code, input logic [2:0] fg, input logic [2:0] bg);
    logic [6:0] ch;
    ch = code[6:0];
    if (code >= 8'h20 && code <= 8'h7E) begin
      refFill(refCol * 6, refRow * 10, 6, 10, bg);
      expDraw.push_back('{x: 8'(refCol * 6), y: 9'(refRow * 10), ch: ch, c: fg});
      for (int i = 0; i < 48; i++)
        if (glyphOn(ch, i)) refFb[(refRow * 10 + i / 6) * 256 + refCol * 6 + i % 6] = fg;
      refCol++;
      if (refCol == C0) begin
        refCol = 0;
        refNewRow(bg);
      end
    end else if (code == 8'h0A) begin
      refCol = 0;
      refNewRow(bg);
    end else if (code == 8'h0D) begin
      refCol = 0;
    end else if (code == 8'h08) begin
      if (refCol > 0) begin
        refCol--;
        refFill(refCol * 6, refRow * 10, 6, 10, bg);
      end
    end else if (code == 8'h0C) begin
      refFill(0, 0, C0 * 6, R0 * 10, bg);
      refCol = 0;
      refRow = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pushCh(input int d, input logic [7:0] code);
    int n = 0;
    @(negedge clk50);
    while (((d == 0) ? i0.chReady : i1.chReady) !== 1'b1 && n < 100) begin
      @(negedge clk50);
      n++;
    end
    chk("push_ready", (d == 0) ? i0.chReady : i1.chReady, 1);
    pushCyc = cyc;
    if (d == 0) begin i0.chData = code; i0.chValid = 1'b1; end
    else        begin i1.chData = code; i1.chValid = 1'b1; end
    @(negedge clk50);
    if (d == 0) i0.chValid = 1'b0;
    else        i1.chValid = 1'b0;
  endtask

  task automatic waitIdle(input int d, input int budget);
    int n = 0;
    while (((d == 0) ? i0.busy : i1.busy) !== 1'b0 && n < budget) begin
      @(negedge clk50);
      n++;
    end
    idleCyc = cyc;
    chk("idle_timeout", (d == 0) ? i0.busy : i1.busy, 0);
  endtask

  task automatic doChar0(input logic [7:0] code, input logic [2:0] fg, input logic [2:0] bg, input int budget);
    i0.fgColor = fg;
    i0.bgColor = bg;
    expDraw.delete();
    obsDraw.delete();
    expWr    = 0;
    wr0      = 0;
    firstWr0 = -1;
    last0    = -1;
    refApply(code, fg, bg);
    pushCh(0, code);
    waitIdle(0, budget);
    chk("cursor_col", i0.cursorCol, refCol);
    chk("cursor_row", i0.cursorRow, refRow);
    chk("fill_writes", wr0, expWr);
    chk("draw_count", obsDraw.size(), expDraw.size());
    for (int i = 0; i < expDraw.size(); i++)
      if (i < obsDraw.size()) chk("draw_params", obsDraw[i], expDraw[i]);
  endtask

  task automatic doChar1(input logic [7:0] code, input int budget);
    wr1    = 0;
    first1 = -1;
    last1  = -1;
    pushCh(1, code);
    waitIdle(1, budget);
  endtask

  task automatic imgCheck(input string tag);
    int m = 0;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 240; x++)
        if (obsFb[y * 256 + x] !== refFb[y * 256 + x]) m++;
    chk(tag, m, 0);
  endtask

  function automatic logic [7:0] randPrint();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] code;
    int         r, acc;
    logic [7:0] others [6];
    others = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h80, 8'hC1};

    for (int a = 0; a < 131072; a++) begin
      obsFb[a] = '0;
      refFb[a] = '0;
    end
    i0.chValid = 0; i0.chData = '0; i0.fgColor = '0; i0.bgColor = '0;
    i1.chValid = 0; i1.chData = '0; i1.fgColor = 3'd1; i1.bgColor = 3'd2;
    refCol = 0; refRow = 0; passErr = 0;
    wr0 = 0; wr1 = 0; firstWr0 = -1; first1 = -1; last0 = -1; last1 = -1;

    repeat (3) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);

    // reset state
    chk("rst_chReady", i0.chReady, 1);
    chk("rst_busy", i0.busy, 0);
    chk("rst_drawChar", i0.gpuDrawChar, 0);
    chk("rst_cursor", {i0.cursorCol, i0.cursorRow}, 0);
    chk("rst_gpuXY", {i0.gpuX, i0.gpuY}, 0);
    chk("rst_gpuCharColor", {i0.gpuChar, i0.gpuColor}, 0);
    chk("rst_fbWrite", i0.fbWrite, 0);

    // narrow console: column wrap, then wrap from the bottom row
    for (int k = 0; k < 4; k++) doChar1(8'h30 + 8'(k), 500);
    chk("n_wrap_lastX", lastX1, 18);
    chk("n_wrap_cursor", {i1.cursorCol, i1.cursorRow}, {6'd0, 5'd1});
    chk("n_wrap_writes", wr1, 60 + 240);
    for (int k = 0; k < 22; k++) doChar1(8'h0A, 500);
    chk("n_row23", {i1.cursorCol, i1.cursorRow}, {6'd0, 5'd23});
    doChar1(8'h0A, 500);
    chk("n_lf_home", {i1.cursorCol, i1.cursorRow}, 0);
    chk("n_lf_writes", wr1, 240);
    chk("n_lf_first", first1, 0);
    chk("n_lf_last", last1, 9 * 256 + 23);

    // first glyph with latency checks
    doChar0(8'h41, 3'b010, 3'b000, 500);
    chk("A_first_write_lat", firstWr0 - pushCyc, 3);
    chk("A_issue_lat", drawCyc - pushCyc, 63);
    chk("A_wait_to_idle", idleCyc - drawCyc, 51);

    // fill row 0, wrap onto row 1
    for (int k = 1; k < 40; k++)
      doChar0(randPrint(), 3'($urandom), 3'($urandom), 4000);
    if (obsDraw.size() > 0) chk("draw40_x", obsDraw[0].x, 234);
    chk("row1_fill_last", last0, 19 * 256 + 239);
    imgCheck("img_row0");

    // random mix of printable and control codes
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 31);
      if (r < 22)      code = randPrint();
      else if (r < 25) code = 8'h0D;
      else if (r < 28) code = 8'h08;
      else if (r < 31) code = others[$urandom_range(0, 5)];
      else             code = 8'h0A;
      doChar0(code, 3'($urandom), 3'($urandom), 4000);
    end
    imgCheck("img_random");

    // backspace at column 0 and an unknown code are no-ops
    doChar0(8'h0D, 3'd1, 3'd6, 500);
    doChar0(8'h08, 3'd1, 3'd6, 500);
    doChar0(8'h07, 3'd1, 3'd6, 500);
    doChar0(randPrint(), 3'd4, 3'd3, 500);

    // stall the GPU, overfill the FIFO, then reset mid-draw
    g0Hold = 1'b1;
    obsDraw.delete();
    i0.chData = 8'h48; i0.chValid = 1'b1;
    @(negedge clk50);
    i0.chValid = 1'b0;
    r = 0;
    while (obsDraw.size() == 0 && r < 500) begin
      @(negedge clk50);
      r++;
    end
    chk("hold_issued", obsDraw.size(), 1);
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk50);
      if (i0.chReady === 1'b1) acc++;
      i0.chData = 8'h50 + 8'(k);
      i0.chValid = 1'b1;
    end
    @(negedge clk50);
    i0.chValid = 1'b0;
    chk("fifo_accepted", acc, 8);
    chk("fifo_full_ready", i0.chReady, 0);
    chk("hold_busy", i0.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", i0.busy, 0);
    chk("abort_cursor", {i0.cursorCol, i0.cursorRow}, 0);
    chk("abort_chReady", i0.chReady, 1);
    @(negedge clk50);
    reset  = 1'b0;
    g0Hold = 1'b0;
    refCol = 0;
    refRow = 0;
    @(negedge clk50);

    // full screen clear
    doChar0(8'h0C, 3'b000, 3'b101, 60000);
    chk("cls_last_addr", last0, 239 * 256 + 239);
    imgCheck("img_cls");

    chk("gpu_passthrough_errs", passErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Character-stream controller that sits in front of the GPU character renderer and owns the shared framebuffer write port. It buffers incoming character codes in a small FIFO and tracks a text cursor. For each code it sequences a background fill of the target cell or row followed by a GPU character draw. It muxes its own fill writes with the GPU's pixel writes onto one framebuffer port.

## Interface
- COLS, 40: text columns; cell pitch 6 px, so max x = 239
- ROWS, 24: text rows; cell pitch 10 px, so max y = 239
- FIFO_DEPTH, 8: character FIFO entries; must be a power of 2
- clk50  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- chValid  in  1  character offered
- chData  in  8  character code
- chReady  out  1  FIFO not full; a push occurs when chValid & chReady
- fgColor  in  3  glyph colour, sampled when a code is popped
- bgColor  in  3  fill colour, sampled when a code is popped
- busy  out  1  FIFO non-empty or state ≠ IDLE
- cursorCol  out  6  current column
- cursorRow  out  5  current row
- gpuX  out  8  held at cellX for the whole draw
- gpuY  out  9  held at cellY for the whole draw
- gpuChar  out  7  chData[6:0] of the popped code
- gpuColor  out  3  latched fgColor
- gpuDrawChar  out  1  one-cycle start pulse
- gpuDrawBox  out  1  constant 0
- gpuXMax  out  8  constant 0
- gpuYMax  out  9  constant 0
- gpuDone  in  1  GPU idle
- gpuWriteMem  in  1  GPU pixel write enable
- gpuWriteData  in  3  GPU pixel write data
- gpuWriteAddress  in  17  GPU pixel write address
- fbWrite  out  1  framebuffer write enable
- fbData  out  3  framebuffer write data
- fbAddress  out  17  framebuffer address, {y[8:0], x[7:0]}

## Operation
- The FIFO is a synchronous register array with read and write pointers. Push and pop may occur in the same cycle, including when the FIFO is full, in which case chReady is 0 and the push is ignored.
- States:
  - IDLE: if the FIFO is non-empty, pop, latch the code, fgColor and bgColor, and go to DECODE.
  - DECODE: set up the next action for the latched code (see code table).
  - FILL: write one bg pixel per cycle, row-major, from (fx0, fy0) to (fx1, fy1) inclusive.
  - ISSUE: gpuDrawChar = 1 for one cycle.
  - WAIT: wait for gpuDone = 1.
  - ADV: update the cursor.
- Code table:
  - 0x20–0x7E: FILL the cell (6×10 at cellX = col·6, cellY = row·10), then ISSUE, WAIT, ADV. ADV sets col+1; if col = COLS−1, col = 0 and the row advances.
  - 0x0A: col = 0; the row advances.
  - 0x0D: col = 0; no fill.
  - 0x08: if col > 0, col−1, then FILL the new cell and return to IDLE. If col = 0, no action.
  - 0x0C: FILL the whole screen (0..COLS·6−1 by 0..ROWS·10−1), cursor to (0,0), then IDLE.
  - Any other code is discarded with no framebuffer writes.
- Row advance: row+1, or 0 if row = ROWS−1, followed by a FILL of the full width of the new row (COLS·6 × 10 px), then IDLE.
- cellX and cellY are maintained incrementally (±6, ±10); no multiplier.
- Port mux:
  - In FILL: fbWrite = 1, fbData = bgColor latch, fbAddress = {fy, fx}.
  - Otherwise the GPU's gpuWriteMem, gpuWriteData and gpuWriteAddress pass straight through.
  - The GPU is guaranteed idle during FILL because ISSUE only follows a completed FILL.
- gpuX, gpuY, gpuChar and gpuColor are registered and stable from ISSUE until WAIT exits.

## Timing
- Reset values:
  - state IDLE, FIFO empty, cursor (0,0).
  - chReady 1, busy 0, gpuDrawChar 0.
  - gpuX/gpuY/gpuChar/gpuColor 0.
  - fbWrite follows gpuWriteMem, which is 0 because the GPU shares the reset.
  - No automatic screen clear.
- A push in cycle t makes the FIFO non-empty at t+1; IDLE pops at t+1 and DECODE runs at t+2.
- FILL lasts exactly (w·h) cycles, one write per cycle:
  - cell: 60 cycles
  - row: 2400 cycles
  - screen: 57600 cycles
- The cycle after FILL's last pixel is ISSUE or IDLE.
- ISSUE at cycle s: gpuDone is low from s+1. WAIT exits on the first cycle gpuDone = 1, which is s+49 for the 48-cycle glyph draw. ADV follows in the next cycle.
- WAIT samples gpuDone only from s+1; no extra guard cycle.
- Asynchronous reset mid-FILL or mid-WAIT aborts immediately. The FIFO contents are lost and partial cell writes remain in the framebuffer.

## Test plan
- Reset, then push 'A' (0x41) with fg = 3'b010, bg = 3'b000.
  - FILL: 60 writes covering x 0..5, y 0..9 with data 0.
  - Then one gpuDrawChar pulse with gpuX = 0, gpuY = 0, gpuChar = 0x41, gpuColor = 2.
  - Cursor ends at (1,0).
- Push 40 printable codes on row 0.
  - The 40th draws at gpuX = 234.
  - The cursor becomes (0,1), and a 2400-write row fill covers y 10..19.
- With the cursor at row 23, push 0x0A.
  - The cursor becomes (0,0), and a row fill covers y 0..9.
- Push 0x0C with bg = 3'b101.
  - Exactly 57600 writes with data 5; the last address is {9'd239, 8'd239}.
  - Cursor ends at (0,0).
- Push 0x08 at col 0 and push 0x07.
  - No fbWrite from the controller and no cursor change for either code.
- Hold the GPU model busy so the controller stays in WAIT and push 9 codes.
  - chReady drops after 8 pushes and the 9th code is not accepted.
  - Asserting reset mid-draw returns busy = 0 and the cursor to (0,0).
